// File: rtl/load_store_unit.sv
// RISC-V load/store unit: single-outstanding bus access FSM with byte lanes and load extension.
// Optional bus-ack watchdog enabled by defining LSU_TIMEOUT_EN (limit set by TIMEOUT_CYCLES).
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemEn,
  input  logic        MemRW,
  input  logic [2:0]  Funct3,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] DataW,
  output logic [31:0] DataR,
  output logic        MemStall,
  output logic        MisAlign,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        bus_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_bus_req;
  logic        r_bus_we;
  logic [31:0] r_bus_addr;
  logic [31:0] r_bus_wdata;
  logic [3:0]  r_bus_be;
  logic [31:0] r_data_r;
  logic        r_misalign;
  logic [1:0]  r_off;
  logic [2:0]  r_f3;

  logic        w_legal_op;
  logic        w_misaligned;
  logic        w_ok;
  logic        w_start;
  logic        w_bad;
  logic [3:0]  w_st_be;
  logic [31:0] w_st_wdata;
  logic [7:0]  w_ld_byte;
  logic [15:0] w_ld_half;
  logic [31:0] w_ld_val;

`ifdef LSU_TIMEOUT_EN
  localparam logic [7:0] LP_TO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] r_to_cnt;
  logic       r_bus_err;
`endif

  always_comb begin
    w_legal_op = 1'b0;
    case (Funct3)
      3'b000, 3'b001, 3'b010: w_legal_op = 1'b1;
      3'b100, 3'b101:         w_legal_op = ~MemRW;
      default:                w_legal_op = 1'b0;
    endcase
  end

  assign w_misaligned = ((Funct3[1:0] == 2'b01) && ALUResultM[0]) ||
                        ((Funct3[1:0] == 2'b10) && (ALUResultM[1:0] != 2'b00));
  assign w_ok    = w_legal_op && !w_misaligned;
  // Gated by reset so MemStall reads 0 while reset is held, whatever MemEn does.
  assign w_start = reset && (r_state == IDLE) && MemEn && w_ok;
  assign w_bad   = (r_state == IDLE) && MemEn && !w_ok;

  always_comb begin
    w_st_be    = 4'b1111;
    w_st_wdata = DataW;
    case (Funct3[1:0])
      2'b00: begin
        w_st_be    = 4'b0001 << ALUResultM[1:0];
        w_st_wdata = {4{DataW[7:0]}};
      end
      2'b01: begin
        w_st_be    = ALUResultM[1] ? 4'b1100 : 4'b0011;
        w_st_wdata = {2{DataW[15:0]}};
      end
      default: begin
        w_st_be    = 4'b1111;
        w_st_wdata = DataW;
      end
    endcase
  end

  always_comb begin
    w_ld_byte = bus_rdata[7:0];
    case (r_off)
      2'd0:    w_ld_byte = bus_rdata[7:0];
      2'd1:    w_ld_byte = bus_rdata[15:8];
      2'd2:    w_ld_byte = bus_rdata[23:16];
      default: w_ld_byte = bus_rdata[31:24];
    endcase
    w_ld_half = r_off[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    w_ld_val  = bus_rdata;
    case (r_f3)
      3'b000:  w_ld_val = {{24{w_ld_byte[7]}}, w_ld_byte};
      3'b100:  w_ld_val = {24'h000000, w_ld_byte};
      3'b001:  w_ld_val = {{16{w_ld_half[15]}}, w_ld_half};
      3'b101:  w_ld_val = {16'h0000, w_ld_half};
      default: w_ld_val = bus_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_bus_be    <= '0;
      r_data_r    <= '0;
      r_misalign  <= 1'b0;
      r_off       <= '0;
      r_f3        <= '0;
`ifdef LSU_TIMEOUT_EN
      r_to_cnt    <= '0;
      r_bus_err   <= 1'b0;
`endif
    end else begin
      r_misalign <= w_bad;
`ifdef LSU_TIMEOUT_EN
      r_bus_err  <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state     <= BUSY;
            r_bus_req   <= 1'b1;
            r_bus_we    <= MemRW;
            r_bus_addr  <= {ALUResultM[31:2], 2'b00};
            r_bus_wdata <= MemRW ? w_st_wdata : 32'h0;
            r_bus_be    <= MemRW ? w_st_be : 4'b1111;
            r_off       <= ALUResultM[1:0];
            r_f3        <= Funct3;
`ifdef LSU_TIMEOUT_EN
            r_to_cnt    <= '0;
`endif
          end
        end
        BUSY: begin
          if (bus_ack) begin
            r_bus_req <= 1'b0;
            r_state   <= DONE;
            if (!r_bus_we) r_data_r <= w_ld_val;
          end
`ifdef LSU_TIMEOUT_EN
          else if (r_to_cnt == LP_TO_LAST) begin
            r_bus_req <= 1'b0;
            r_bus_err <= 1'b1;
            r_state   <= DONE;
            if (!r_bus_we) r_data_r <= '0;
          end else begin
            r_to_cnt <= r_to_cnt + 8'd1;
          end
`endif
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef LSU_TIMEOUT_EN
  assign bus_err = r_bus_err;
`else
  assign bus_err = 1'b0;
  // Watchdog absent: the limit only shapes elaboration, no hardware uses it.
  if (TIMEOUT_CYCLES == 0) begin : g_no_watchdog
  end
`endif

  assign MemStall  = w_start || (r_state == BUSY);
  assign MisAlign  = r_misalign;
  assign DataR     = r_data_r;
  assign bus_req   = r_bus_req;
  assign bus_we    = r_bus_we;
  assign bus_addr  = r_bus_addr;
  assign bus_wdata = r_bus_wdata;
  assign bus_be    = r_bus_be;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized self-checking bench for load_store_unit against a behavioural access model.
// Watchdog scenario runs only when LSU_TIMEOUT_EN is defined.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemEn;
  logic        MemRW;
  logic [2:0]  Funct3;
  logic [31:0] ALUResultM;
  logic [31:0] DataW;
  logic [31:0] DataR;
  logic        MemStall;
  logic        MisAlign;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        bus_err;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_datar = '0;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .MemEn(MemEn), .MemRW(MemRW), .Funct3(Funct3),
    .ALUResultM(ALUResultM), .DataW(DataW), .DataR(DataR), .MemStall(MemStall),
    .MisAlign(MisAlign), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_be(bus_be), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .bus_err(bus_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic m_legal(input logic rw, input logic [2:0] f3, input logic [31:0] a);
    case (f3)
      3'd0:    return 1'b1;
      3'd1:    return a[0] == 1'b0;
      3'd2:    return a[1:0] == 2'b00;
      3'd4:    return !rw;
      3'd5:    return !rw && (a[0] == 1'b0);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] sh, b, h;
    sh = rd >> (8 * a[1:0]);
    b  = sh & 32'hFF;
    h  = sh & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 32'd128) ? b - 32'd256 : b;
      3'd4:    return b;
      3'd1:    return (h >= 32'd32768) ? h - 32'd65536 : h;
      3'd5:    return h;
      default: return rd;
    endcase
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
    case (f3)
      3'd0:    return (wd & 32'hFF) * 32'h01010101;
      3'd1:    return (wd & 32'hFFFF) * 32'h00010001;
      default: return wd;
    endcase
  endfunction

  function automatic logic [3:0] m_be(input logic rw, input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] v;
    if (!rw) return 4'hF;
    case (f3)
      3'd0:    v = 32'd1 << a[1:0];
      3'd1:    v = 32'd3 << a[1:0];
      default: v = 32'd15;
    endcase
    return v[3:0];
  endfunction

  task automatic run_access(input logic rw, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [31:0] rd, input int dly,
                            input string tag);
    int stalls, reqs, misal, post;
    logic adv, ok, we_s;
    logic [3:0] be_s;
    logic [31:0] addr_s, wd_s;
    ok = m_legal(rw, f3, addr);
    stalls = 0; reqs = 0; misal = 0; post = 0; adv = 1'b0;
    we_s = 1'b0; be_s = '0; addr_s = '0; wd_s = '0;
    @(negedge clk);
    MemEn = 1'b1; MemRW = rw; Funct3 = f3; ALUResultM = addr; DataW = wd; bus_ack = 1'b0;
    for (int cyc = 0; cyc < 40 && post < 3; cyc++) begin
      #1;
      if (MemStall) stalls++;
      if (MisAlign) misal++;
      if (bus_req) begin
        if (reqs == 0) begin
          we_s = bus_we; be_s = bus_be; addr_s = bus_addr; wd_s = bus_wdata;
        end
        reqs++;
        bus_ack = (reqs == dly + 1);
        bus_rdata = bus_ack ? rd : $urandom;
      end else begin
        bus_ack = ($urandom_range(0, 3) == 0);
        bus_rdata = $urandom;
      end
      if (adv) post++;
      if (MemEn && !MemStall) adv = 1'b1;
      @(negedge clk);
      if (adv) MemEn = 1'b0;
    end
    bus_ack = 1'b0;
    MemEn = 1'b0;
    check({tag, " advance"}, 32'(adv), 32'd1);
    if (ok) begin
      check({tag, " stalls"}, stalls, dly + 2);
      check({tag, " req_cycles"}, reqs, dly + 1);
      check({tag, " misalign"}, misal, 0);
      check({tag, " we"}, 32'(we_s), 32'(rw));
      check({tag, " be"}, 32'(be_s), 32'(m_be(rw, f3, addr)));
      check({tag, " addr"}, addr_s, addr & 32'hFFFF_FFFC);
      if (rw) check({tag, " wdata"}, wd_s, m_wdata(f3, wd));
      else exp_datar = m_load(f3, addr, rd);
    end else begin
      check({tag, " stalls"}, stalls, 0);
      check({tag, " req_cycles"}, reqs, 0);
      check({tag, " misalign"}, misal, 1);
    end
    check({tag, " datar"}, DataR, exp_datar);
  endtask

  initial begin
    int busy;
    reset = 1'b0; MemEn = 1'b0; MemRW = 1'b0; Funct3 = '0; ALUResultM = '0;
    DataW = '0; bus_ack = 1'b0; bus_rdata = '0;
    repeat (3) @(negedge clk);
    MemEn = 1'b1;
    #1;
    check("rst stall", 32'(MemStall), 32'd0);
    check("rst req", 32'(bus_req), 32'd0);
    check("rst we", 32'(bus_we), 32'd0);
    check("rst misalign", 32'(MisAlign), 32'd0);
    check("rst err", 32'(bus_err), 32'd0);
    check("rst addr", bus_addr, 32'd0);
    check("rst wdata", bus_wdata, 32'd0);
    check("rst be", 32'(bus_be), 32'd0);
    check("rst datar", DataR, 32'd0);
    MemEn = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    // Load abandoned by reset in its 3rd BUSY cycle, ack would have come later.
    @(negedge clk);
    MemEn = 1'b1; MemRW = 1'b0; Funct3 = 3'd2; ALUResultM = 32'h40; bus_ack = 1'b0;
    busy = 0;
    for (int i = 0; i < 20 && busy < 3; i++) begin
      #1;
      if (bus_req) busy++;
      if (busy < 3) @(negedge clk);
    end
    check("rstmid reached busy", busy, 3);
    reset = 1'b0; MemEn = 1'b0;
    #1;
    check("rstmid req", 32'(bus_req), 32'd0);
    check("rstmid stall", 32'(MemStall), 32'd0);
    check("rstmid datar", DataR, 32'd0);
    @(negedge clk);
    bus_ack = 1'b1; bus_rdata = 32'h5555_AAAA;
    @(negedge clk);
    bus_ack = 1'b0; reset = 1'b1;
    repeat (3) begin
      @(negedge clk); bus_ack = 1'b1;
      #1;
      check("rstmid idle req", 32'(bus_req), 32'd0);
      check("rstmid idle datar", DataR, 32'd0);
    end
    bus_ack = 1'b0;
    exp_datar = '0;

    run_access(1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 32'h0, 0, "sw_100");
    run_access(1'b0, 3'd0, 32'h203, 32'h0, 32'h80FF_FF7F, 1, "lb_203");
    check("lb_203 const", DataR, 32'hFFFF_FF80);
    run_access(1'b0, 3'd4, 32'h203, 32'h0, 32'h80FF_FF7F, 2, "lbu_203");
    check("lbu_203 const", DataR, 32'h0000_0080);
    run_access(1'b1, 3'd1, 32'h102, 32'h0000_1234, 32'h0, 0, "sh_102");
    run_access(1'b0, 3'd2, 32'h101, 32'h0, 32'h1357_9BDF, 0, "lw_101");
    check("lw_101 const", DataR, 32'h0000_0080);

    for (int k = 0; k < 250; k++) begin
      logic rw;
      logic [2:0] f3;
      rw = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      run_access(rw, f3, $urandom, $urandom, $urandom, $urandom_range(0, 2), "rand");
    end

`ifdef LSU_TIMEOUT_EN
    begin
      int reqs, errs, stalls, post;
      logic adv;
      run_access(1'b0, 3'd2, 32'h80, 32'h0, 32'hCAFE_F00D, 0, "pre_to");
      reqs = 0; errs = 0; stalls = 0; post = 0; adv = 1'b0;
      @(negedge clk);
      MemEn = 1'b1; MemRW = 1'b0; Funct3 = 3'd2; ALUResultM = 32'h84; bus_ack = 1'b0;
      for (int cyc = 0; cyc < 40 && post < 3; cyc++) begin
        #1;
        if (MemStall) stalls++;
        if (bus_req) reqs++;
        if (bus_err) errs++;
        if (adv) post++;
        if (MemEn && !MemStall) adv = 1'b1;
        @(negedge clk);
        if (adv) MemEn = 1'b0;
      end
      MemEn = 1'b0;
      check("to advance", 32'(adv), 32'd1);
      check("to req_cycles", reqs, 4);
      check("to err_pulse", errs, 1);
      check("to stalls", stalls, 5);
      check("to datar", DataR, 32'd0);
      exp_datar = '0;
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
